// File: rtl/codegen_checker.sv
// codegen_checker
//   Downstream checker for the pattern generator's 32-bit word stream. The low
//   CNT_W bits of each word carry an incrementing counter, and the upper bits
//   must be zero.
//   The checker first acquires lock on the sequence (SEARCH -> LOCKED). While
//   locked it flags and counts mismatches. Sustained mismatches drop it back to
//   SEARCH.
//
// Parameters
//   CNT_W     width of counter field in in_data[CNT_W-1:0]
//   LOCK_CNT  consecutive good compares after the seed needed to lock
//   LOSS_CNT  consecutive bad compares while locked that force SEARCH
//   ERRCNT_W  width of the saturating error counter
//
// Ports
//   clk        clock
//   rst_l      asynchronous active-low reset
//   in_valid   in_data valid this cycle
//   in_data    word from generator
//   clr        synchronous clear of err_cnt, word_cnt (and err_sticky)
//   locked     1 while in LOCKED
//   err_pulse  one-cycle pulse per mismatch seen while LOCKED
//   err_cnt    saturating count of mismatches while LOCKED
//   word_cnt   count of accepted words, wraps
//   err_sticky (CODEGEN_CHK_STICKY_EN only) set on first LOCKED mismatch,
//              cleared by clr or reset
//
// Build option: define CODEGEN_CHK_STICKY_EN to add err_sticky.

module codegen_checker #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                in_valid,
  input  logic [31:0]         in_data,
  input  logic                clr,
  output logic                locked,
  output logic                err_pulse,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [31:0]         word_cnt
`ifdef CODEGEN_CHK_STICKY_EN
  ,
  output logic                err_sticky
`endif
);

  localparam int GR_W = $clog2(LOCK_CNT + 1);
  localparam int BR_W = $clog2(LOSS_CNT + 1);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic                seeded_q, seeded_d;
  logic [CNT_W-1:0]    exp_q, exp_d;
  logic [GR_W-1:0]     good_q, good_d;
  logic [BR_W-1:0]     bad_q, bad_d;
  logic                pulse_d;
  logic [ERRCNT_W-1:0] errcnt_d;
  logic [31:0]         wordcnt_d;
  logic [CNT_W-1:0]    data_lo;
  logic                upper_zero;
  logic                word_good;
`ifdef CODEGEN_CHK_STICKY_EN
  logic                sticky_d;
`endif

  assign data_lo    = in_data[CNT_W-1:0];
  // A shift works even when CNT_W is 32 and there are no upper bits.
  assign upper_zero = ((in_data >> CNT_W) == '0);
  assign word_good  = upper_zero && (data_lo == exp_q);
  assign locked     = (state_q == LOCKED);

  always_comb begin
    state_d   = state_q;
    seeded_d  = seeded_q;
    exp_d     = exp_q;
    good_d    = good_q;
    bad_d     = bad_q;
    pulse_d   = 1'b0;
    errcnt_d  = err_cnt;
    wordcnt_d = word_cnt;
`ifdef CODEGEN_CHK_STICKY_EN
    sticky_d  = err_sticky;
`endif

    if (in_valid) begin
      wordcnt_d = word_cnt + 32'd1;
      unique case (state_q)
        SEARCH: begin
          if (!seeded_q) begin
            seeded_d = 1'b1;
            exp_d    = data_lo + CNT_W'(1);
            good_d   = '0;
          end else if (word_good) begin
            exp_d  = exp_q + CNT_W'(1);
            good_d = good_q + GR_W'(1);
            if (good_q == GR_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            exp_d  = data_lo + CNT_W'(1);
            good_d = '0;
          end
        end
        LOCKED: begin
          exp_d = exp_q + CNT_W'(1);
          if (word_good) begin
            bad_d = '0;
          end else begin
            pulse_d = 1'b1;
            if (err_cnt != '1) errcnt_d = err_cnt + ERRCNT_W'(1);
`ifdef CODEGEN_CHK_STICKY_EN
            sticky_d = 1'b1;
`endif
            if (bad_q == BR_W'(LOSS_CNT - 1)) begin
              // The word that loses lock becomes the new seed. seeded_q
              // therefore stays set, and the next word is compared.
              state_d = SEARCH;
              exp_d   = data_lo + CNT_W'(1);
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + BR_W'(1);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clr) begin
      errcnt_d  = '0;
      wordcnt_d = '0;
`ifdef CODEGEN_CHK_STICKY_EN
      sticky_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= SEARCH;
      seeded_q   <= 1'b0;
      exp_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      word_cnt   <= '0;
`ifdef CODEGEN_CHK_STICKY_EN
      err_sticky <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      seeded_q   <= seeded_d;
      exp_q      <= exp_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_pulse  <= pulse_d;
      err_cnt    <= errcnt_d;
      word_cnt   <= wordcnt_d;
`ifdef CODEGEN_CHK_STICKY_EN
      err_sticky <= sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_codegen_checker.sv
module tb_codegen_checker;

  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          clr = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic [EW-1:0] err_cnt;
  logic [31:0]   word_cnt;
`ifdef CODEGEN_CHK_STICKY_EN
  logic          err_sticky;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers)
  bit          m_locked, m_seeded, m_pulse, m_sticky;
  int unsigned m_exp, m_good, m_bad, m_err, m_words;

  codegen_checker #(
    .CNT_W   (16),
    .LOCK_CNT(4),
    .LOSS_CNT(3),
    .ERRCNT_W(EW)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
`ifdef CODEGEN_CHK_STICKY_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_pulse = 0; m_sticky = 0;
    m_exp = 0; m_good = 0; m_bad = 0; m_err = 0; m_words = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit c);
    int unsigned lo;
    bit good;
    lo = d & 32'hFFFF;
    good = (d[31:16] == 16'h0) && (lo == m_exp);
    m_pulse = 0;
    if (v) begin
      m_words = m_words + 1;
      if (!m_locked) begin
        if (!m_seeded) begin
          m_seeded = 1; m_exp = (lo + 1) % 65536; m_good = 0;
        end else if (good) begin
          m_exp = (m_exp + 1) % 65536;
          m_good = m_good + 1;
          if (m_good == 4) begin m_locked = 1; m_bad = 0; end
        end else begin
          m_exp = (lo + 1) % 65536; m_good = 0;
        end
      end else begin
        m_exp = (m_exp + 1) % 65536;
        if (good) m_bad = 0;
        else begin
          m_pulse = 1;
          m_sticky = 1;
          if (m_err < (1 << EW) - 1) m_err = m_err + 1;
          m_bad = m_bad + 1;
          if (m_bad == 3) begin
            m_locked = 0; m_exp = (lo + 1) % 65536; m_good = 0; m_bad = 0;
          end
        end
      end
    end
    if (c) begin m_err = 0; m_words = 0; m_sticky = 0; end
  endtask

  // Drive one cycle, advance the model, leave time 1 unit after the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit c);
    in_valid = v; in_data = d; clr = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; clr = 0;
    rst_l = 0;
    #2;
    model_reset();
    @(negedge clk);
    rst_l = 1;
  endtask

  task automatic test_reset();
    rst_l = 0;
    #2;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b want=0", err_pulse); end
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_cnt); end
    total++; if (word_cnt !== '0) begin bad++; $display("FAIL reset_wordcnt got=%0d want=0", word_cnt); end
`ifdef CODEGEN_CHK_STICKY_EN
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%0b want=0", err_sticky); end
`endif
    model_reset();
    @(negedge clk);
    rst_l = 1;
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'(i), 0);
      total++; if (locked !== (i == 4)) begin bad++; $display("FAIL lock_seq i=%0d locked=%0b want=%0b", i, locked, (i == 4)); end
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL lock_pulse i=%0d got=%0b want=0", i, err_pulse); end
    end
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL lock_errcnt got=%0d want=0", err_cnt); end
    total++; if (word_cnt !== 32'd5) begin bad++; $display("FAIL lock_wordcnt got=%0d want=5", word_cnt); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d = (32'hFFF9 + 32'(i)) & 32'hFFFF;
      step(1, d, 0);
      total++; if (locked !== (i >= 4)) begin bad++; $display("FAIL wrap_locked d=%h got=%0b want=%0b", d, locked, (i >= 4)); end
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL wrap_pulse d=%h got=%0b want=0", d, err_pulse); end
    end
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL wrap_errcnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_single_err();
    do_reset();
    for (int d = 'h0B; d <= 'h0F; d++) step(1, 32'(d), 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL serr_prelock got=%0b want=1", locked); end
    step(1, 32'h33, 0);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL serr_pulse got=%0b want=1", err_pulse); end
    total++; if (err_cnt !== EW'(1)) begin bad++; $display("FAIL serr_cnt got=%0d want=1", err_cnt); end
    step(1, 32'h11, 0);
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL serr_pulse2 got=%0b want=0", err_pulse); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL serr_locked got=%0b want=1", locked); end
    step(1, 32'h12, 0);
    total++; if (err_pulse !== 1'b0 || err_cnt !== EW'(1)) begin bad++; $display("FAIL serr_next pulse=%0b cnt=%0d want 0/1", err_pulse, err_cnt); end
  endtask

  task automatic test_loss();
    logic [31:0] bw [3];
    bw[0] = 32'h0100_0020; bw[1] = 32'h5; bw[2] = 32'h5;
    for (int d = 'h13; d <= 'h1F; d++) step(1, 32'(d), 0);
    for (int k = 0; k < 3; k++) begin
      step(1, bw[k], 0);
      total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL loss_pulse k=%0d got=%0b want=1", k, err_pulse); end
      total++; if (err_cnt !== EW'(2 + k)) begin bad++; $display("FAIL loss_cnt k=%0d got=%0d want=%0d", k, err_cnt, 2 + k); end
      total++; if (locked !== (k < 2)) begin bad++; $display("FAIL loss_locked k=%0d got=%0b want=%0b", k, locked, (k < 2)); end
    end
    for (int d = 6; d <= 9; d++) begin
      step(1, 32'(d), 0);
      total++; if (locked !== (d == 9)) begin bad++; $display("FAIL relock d=%0d got=%0b want=%0b", d, locked, (d == 9)); end
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL relock_pulse d=%0d got=%0b want=0", d, err_pulse); end
    end
  endtask

  task automatic test_idle();
    logic [31:0] wc;
    step(1, 32'hA, 0);
    step(1, 32'hB, 0);
    wc = word_cnt;
    for (int i = 0; i < 10; i++) begin
      step(0, $urandom, 0);
      total++; if (word_cnt !== wc || err_pulse !== 1'b0 || locked !== 1'b1 || err_cnt !== EW'(m_err))
        begin bad++; $display("FAIL idle i=%0d wc=%0d pulse=%0b locked=%0b errcnt=%0d", i, word_cnt, err_pulse, locked, err_cnt); end
    end
    step(1, 32'hC, 0);
    step(1, 32'hD, 0);
    total++; if (err_pulse !== 1'b0 || word_cnt !== wc + 32'd2) begin bad++; $display("FAIL idle_resume pulse=%0b wc=%0d want 0/%0d", err_pulse, word_cnt, wc + 2); end
  endtask

  task automatic test_clr();
    step(1, 32'h77, 1);
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL clr_errcnt got=%0d want=0", err_cnt); end
    total++; if (word_cnt !== '0) begin bad++; $display("FAIL clr_wordcnt got=%0d want=0", word_cnt); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%0b want=1", err_pulse); end
`ifdef CODEGEN_CHK_STICKY_EN
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL clr_sticky_win got=%0b want=0", err_sticky); end
`endif
    step(1, 32'h99, 0);
    step(1, 32'h99, 0);
    total++; if (locked !== 1'b0 || err_cnt !== EW'(2)) begin bad++; $display("FAIL clr_loss locked=%0b cnt=%0d want 0/2", locked, err_cnt); end
    for (int d = 'h9A; d <= 'hA0; d++) step(1, 32'(d), 0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_relock got=%0b want=1", locked); end
`ifdef CODEGEN_CHK_STICKY_EN
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL sticky_hold got=%0b want=1", err_sticky); end
`endif
    step(0, 32'h0, 1);
    total++; if (err_cnt !== '0 || word_cnt !== '0) begin bad++; $display("FAIL clr_idle cnt=%0d wc=%0d want 0/0", err_cnt, word_cnt); end
`ifdef CODEGEN_CHK_STICKY_EN
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL sticky_clr got=%0b want=0", err_sticky); end
`endif
  endtask

  task automatic test_random();
    int burst;
    bit v, c;
    logic [31:0] d;
    int r;
    burst = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom % 8) != 0;
      c = ($urandom % 250) == 0;
      r = int'($urandom % 100);
      if (burst == 0 && r >= 96) burst = 3;
      if (burst > 0) begin
        d = 32'((m_exp + 7) % 65536);
        if (v) burst--;
      end else if (r < 86) d = 32'(m_exp);
      else if (r < 92) d = $urandom & 32'hFFFF;
      else d = $urandom;
      step(v, d, c);
      total++; if (locked !== m_locked || err_pulse !== m_pulse || err_cnt !== EW'(m_err) || word_cnt !== m_words)
        begin bad++; $display("FAIL rand i=%0d locked=%0b/%0b pulse=%0b/%0b errcnt=%0d/%0d wc=%0d/%0d", i, locked, m_locked, err_pulse, m_pulse, err_cnt, m_err, word_cnt, m_words); end
`ifdef CODEGEN_CHK_STICKY_EN
      total++; if (err_sticky !== m_sticky) begin bad++; $display("FAIL rand_sticky i=%0d got=%0b want=%0b", i, err_sticky, m_sticky); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    for (int d = 0; d < 6; d++) step(1, 32'(d + 'h20), 0);
    step(1, 32'h5555, 0);
    rst_l = 0;
    #1;
    total++; if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== '0 || word_cnt !== '0)
      begin bad++; $display("FAIL midrst locked=%0b pulse=%0b cnt=%0d wc=%0d want all 0", locked, err_pulse, err_cnt, word_cnt); end
    model_reset();
    @(negedge clk);
    rst_l = 1;
    for (int d = 'h40; d <= 'h44; d++) begin
      step(1, 32'(d), 0);
      total++; if (locked !== (d == 'h44) || err_pulse !== 1'b0) begin bad++; $display("FAIL midrst_seed d=%0h locked=%0b pulse=%0b", d, locked, err_pulse); end
    end
    total++; if (word_cnt !== 32'd5) begin bad++; $display("FAIL midrst_wc got=%0d want=5", word_cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_single_err();
    test_loss();
    test_idle();
    test_clr();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
